round_robin_arbiter: RTL and testbench
======================================

# round_robin_arbiter

Shares one downstream resource among `N = 2**A` requesters using rotating priority. The arbiter holds a grant until the resource signals `release`, then moves priority past the last winner. It is the sequencing front end for muxed datapaths such as AXI channel muxes. The winning index is registered, and the one-hot grant is decoded from that index.

## Interface
- `A`, default 2: index width (≥1).
- `N`, default `2**A`: number of requesters (derived; do not override).
- `aclk`  in  1: clock; all state updates on the rising edge.
- `aresetn`  in  1: reset, asynchronous assert, active-low.
- `request`  in  N: per-requester request level; bit i = requester i wants the resource.
- `release`  in  1: from the resource; the current owner's transaction completes this cycle.
- `grant`  out  N: one-hot grant, all-zero when idle.
- `grant_index`  out  A: binary index of the owner; valid only when `grant_valid`=1.
- `grant_valid`  out  1: a grant is active.

## Operation
- States:
  - IDLE: no owner.
  - BUSY: `grant_index` owns the resource.
- Priority pointer `ptr` (A bits): the highest-priority index for the next arbitration. Search order is `ptr, ptr+1, …, ptr+N-1`, modulo N (natural A-bit wrap).
- IDLE:
  - If any `request` bit is set, select the first set bit in search order.
  - Register the winner into `grant_index` and go to BUSY.
  - If no request, stay in IDLE.
- BUSY, end condition: `release`=1, or `request[grant_index]`=0 (owner withdrew).
- BUSY, no end condition: hold `grant_index`. Other requests are ignored, and the grant never changes mid-transaction.
- BUSY, end condition occurs:
  - Set `ptr ← grant_index+1`, wrapping N-1 to 0.
  - Re-arbitrate in the same cycle over `request` with the owner's bit masked, using the new pointer.
  - If there is a winner, load it and stay in BUSY (no bubble).
  - Otherwise go to IDLE.
- Owner re-requesting after release: its bit is masked for that one cycle only. It competes normally afterwards, now at lowest priority.
- `ptr` changes only on an end condition, never on the IDLE→BUSY transition.
- `grant` is `one_hot_encoder(grant_index)` ANDed with `grant_valid`. It is never multi-hot and never X after reset.

## Timing
- Reset (async, `aresetn`=0):
  - state = IDLE, `ptr` = 0, `grant_index` = 0.
  - `grant_valid` = 0, `grant` = 0.
  - Outputs settle without a clock edge.
- Reset during BUSY drops the grant immediately. After deassertion, arbitration restarts from `ptr` = 0.
- Latency:
  - `request` rising in IDLE gives `grant_valid`/`grant` on the next rising edge (1 cycle).
  - An end condition at edge k gives the new owner's grant visible after edge k (0 idle cycles).
- `release` or request drop with state IDLE: ignored, and `ptr` is unchanged.
- `release` and owner request drop in the same cycle: one end condition, handled once.
- Single requester, request held continuously with `release` each transaction: re-granted every other cycle. The masked cycle forces IDLE; this is required, as it guarantees the bubble a lone owner sees.
- All outputs are registered or a decode of registered state. There is no combinational path from `request`/`release` to `grant`.

## Structure
- Shared package `arbiter_pkg`: state enum `arb_state_t {ARB_IDLE, ARB_BUSY}` and a function `rr_pick(req, ptr)` returning the `{found, index}` pair. The function is reused by other muxes.
- Sub-module: `one_hot_encoder #(.A(A))` instantiated once to decode `grant_index` into `grant`.
- No other hierarchy. Next-state and winner search are combinational `always_comb`, and registers are in one `always_ff` sensitive to `aresetn` negedge.

## Test plan
- Reset checks:
  - Assert `aresetn`=0 mid-BUSY with owner 2 → `grant`=0000 and `grant_valid`=0 without a clock.
  - After release from reset, `request`=0100 → `grant`=0100 one cycle later.
- Fair rotation (A=2):
  - `request`=1111 held, `release` pulsed every 3rd cycle → owners 0,1,2,3,0 in order.
  - No idle cycle between owners.
- Hold: owner 1 granted, `request` changes 0010→1111 without `release` → `grant` stays 0010 until `release`, then becomes 0100.
- Withdrawal: owner 3 granted, `request[3]` drops with others zero → IDLE next cycle with `ptr`=0; then `request`=1001 → grant 0001.
- Lone requester: `request`=0001 held, `release` each BUSY cycle → `grant_valid` toggles 1,0,1,0; `ptr` ends at 1.
- Wrap: `ptr`=3, `request`=0011 → grant 0001 (index 0 before 1).

Source files
------------

// File: rtl/arbiter_pkg.sv
// Shared arbitration types and the rotating-priority search used by the
// round-robin arbiter and other request muxes.
package arbiter_pkg;

  localparam int unsigned RR_MAX_A = 5;
  localparam int unsigned RR_MAX_N = 1 << RR_MAX_A;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic                found;
    logic [RR_MAX_A-1:0] index;
  } rr_pick_t;

  // First set bit of req in the order ptr, ptr+1, ... wrapping modulo 2**a.
  // Callers narrower than RR_MAX_A zero-extend req/ptr and truncate index.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_N-1:0] req,
                                       input logic [RR_MAX_A-1:0] ptr,
                                       input int unsigned         a);
    rr_pick_t    res;
    int unsigned n;
    int unsigned cand;
    res = '0;
    n   = 32'd1 << a;
    for (int unsigned i = 0; i < RR_MAX_N; i++) begin
      cand = (32'(ptr) + i) & (n - 32'd1);
      if (!res.found && (i < n) && req[cand[RR_MAX_A-1:0]]) begin
        res.found = 1'b1;
        res.index = cand[RR_MAX_A-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/one_hot_encoder.sv
// Binary index to one-hot decode; used to turn the registered winner into a grant vector.
module one_hot_encoder #(
  parameter int A = 2
) (
  input  logic [A-1:0]    index_i,
  output logic [2**A-1:0] onehot_o
);

  generate
    for (genvar gi = 0; gi < 2**A; gi++) begin : g_bit
      assign onehot_o[gi] = (index_i == A'(gi));
    end
  endgenerate

endmodule

// File: rtl/round_robin_arbiter.sv
// Rotating-priority arbiter: holds a registered owner until release or withdrawal,
// then re-arbitrates in the same cycle with the previous owner masked.
module round_robin_arbiter
  import arbiter_pkg::*;
#(
  parameter  int A = 2,
  localparam int N = 2**A
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic [N-1:0] request,
  input  logic         release_i,   // "release" is a reserved word in SystemVerilog
  output logic [N-1:0] grant,
  output logic [A-1:0] grant_index,
  output logic         grant_valid
);

  arb_state_t   state_q, state_d;
  logic [A-1:0] ptr_q, ptr_d;
  logic [A-1:0] index_q, index_d;
  logic [N-1:0] owner_onehot;
  logic [N-1:0] masked_req;
  logic [A-1:0] ptr_after;
  logic         end_cond;
  rr_pick_t     pick_idle;
  rr_pick_t     pick_busy;

  one_hot_encoder #(.A(A)) u_one_hot_encoder (
    .index_i  (index_q),
    .onehot_o (owner_onehot)
  );

  assign grant_valid = (state_q == ARB_BUSY);
  assign grant_index = index_q;
  assign grant       = owner_onehot & {N{grant_valid}};

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    index_d    = index_q;
    end_cond   = release_i | ~request[index_q];
    ptr_after  = index_q + A'(1);
    masked_req = request & ~owner_onehot;
    pick_idle  = rr_pick(RR_MAX_N'(request), RR_MAX_A'(ptr_q), A);
    pick_busy  = rr_pick(RR_MAX_N'(masked_req), RR_MAX_A'(ptr_after), A);
    case (state_q)
      ARB_IDLE: begin
        if (pick_idle.found) begin
          index_d = A'(pick_idle.index);
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (end_cond) begin
          ptr_d = ptr_after;
          if (pick_busy.found) begin
            index_d = A'(pick_busy.index);
          end else begin
            state_d = ARB_IDLE;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      index_q <= index_d;
    end
  end

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Scoreboard bench: stimulus pushes reference-model expectations, a monitor
// compares them against the arbiter outputs each cycle.
module tb_round_robin_arbiter;

  localparam int A = 2;
  localparam int N = 4;

  logic         aclk;
  logic         aresetn;
  logic [N-1:0] request;
  logic         release_i;
  logic [N-1:0] grant;
  logic [A-1:0] grant_index;
  logic         grant_valid;

  typedef struct {
    string        tag;
    logic [N-1:0] g;
    logic         v;
    logic [A-1:0] idx;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // reference model state: owner (-1 = nobody) and priority pointer
  int   m_owner;
  int   m_ptr;

  round_robin_arbiter #(.A(A)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .request     (request),
    .release_i   (release_i),
    .grant       (grant),
    .grant_index (grant_index),
    .grant_valid (grant_valid)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  function automatic int first_from(input logic [N-1:0] req, input int start);
    for (int k = 0; k < N; k++) begin
      if (req[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = 0;
  endtask

  task automatic model_step(input logic [N-1:0] req, input logic rel);
    logic [N-1:0] others;
    if (m_owner < 0) begin
      m_owner = first_from(req, m_ptr);
    end else if (rel || !req[m_owner]) begin
      m_ptr   = (m_owner + 1) % N;
      others  = req;
      others[m_owner] = 1'b0;
      m_owner = first_from(others, m_ptr);
    end
  endtask

  task automatic cycle(input string tag, input logic [N-1:0] req, input logic rel);
    exp_t e;
    @(negedge aclk);
    request   = req;
    release_i = rel;
    model_step(req, rel);
    e.tag = tag;
    e.v   = (m_owner >= 0);
    e.g   = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    e.idx = (m_owner >= 0) ? A'(m_owner) : '0;
    sb_q.push_back(e);
  endtask

  task automatic check_now(input string tag, input logic [N-1:0] g, input logic v);
    checks++;
    if (grant !== g || grant_valid !== v) begin
      errors++;
      $display("FAIL %s: grant=%b valid=%b, required grant=%b valid=%b",
               tag, grant, grant_valid, g, v);
    end else begin
      $display("ok   %s: grant=%b valid=%b", tag, grant, grant_valid);
    end
  endtask

  // Monitor: compare the DUT against the oldest expectation after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge aclk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        checks++;
        if (grant !== e.g || grant_valid !== e.v || (e.v && grant_index !== e.idx)) begin
          errors++;
          $display("FAIL %s: grant=%b valid=%b index=%0d, required grant=%b valid=%b index=%0d",
                   e.tag, grant, grant_valid, grant_index, e.g, e.v, e.idx);
        end else begin
          $display("ok   %s: grant=%b valid=%b index=%0d", e.tag, grant, grant_valid, grant_index);
        end
      end
    end
  end

  initial begin
    request   = '0;
    release_i = 1'b0;
    aresetn   = 1'b0;
    model_reset();
    #1;
    check_now("reset_async", 4'b0000, 1'b0);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;

    // reset-release then single request 0100
    cycle("idle", 4'b0000, 1'b0);
    cycle("first_grant", 4'b0100, 1'b0);
    cycle("hold_owner2", 4'b0100, 1'b0);

    // asynchronous reset while owner 2 is busy
    @(posedge aclk);
    #3;
    aresetn = 1'b0;
    #1;
    check_now("reset_mid_busy", 4'b0000, 1'b0);
    model_reset();
    @(negedge aclk);
    request = '0;
    @(negedge aclk);
    aresetn = 1'b1;
    cycle("post_reset", 4'b0100, 1'b0);
    cycle("post_reset_rel", 4'b0000, 1'b1);

    // fair rotation: all request, release every third cycle
    for (int k = 0; k < 15; k++) cycle("rotation", 4'b1111, (k % 3) == 2);
    cycle("rot_drain", 4'b0000, 1'b1);

    // hold: owner stays granted while others appear, until release
    cycle("hold_setup", 4'b0010, 1'b0);
    for (int k = 0; k < 3; k++) cycle("hold_others", 4'b1111, 1'b0);
    cycle("hold_release", 4'b1111, 1'b1);
    cycle("hold_drain", 4'b0000, 1'b1);

    // withdrawal by owner 3 with nobody else waiting
    cycle("wd_setup", 4'b1000, 1'b0);
    cycle("wd_setup2", 4'b1000, 1'b0);
    cycle("wd_drop", 4'b0000, 1'b0);
    cycle("wd_regrant", 4'b1001, 1'b0);
    cycle("wd_drain", 4'b0000, 1'b1);

    // lone requester with release every cycle
    for (int k = 0; k < 6; k++) cycle("lone", 4'b0001, 1'b1);
    cycle("lone_drain", 4'b0000, 1'b0);

    // wrap: drive pointer to 3, then 0011 must pick index 0
    cycle("wrap_setup", 4'b0100, 1'b0);
    cycle("wrap_rel", 4'b0000, 1'b1);
    cycle("wrap_pick", 4'b0011, 1'b0);
    cycle("wrap_drain", 4'b0000, 1'b1);

    // release/request noise while idle
    cycle("idle_noise", 4'b0000, 1'b1);

    // randomized traffic with sticky requests
    begin
      logic [N-1:0] r;
      r = '0;
      for (int k = 0; k < 400; k++) begin
        if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, 15));
        else if ($urandom_range(0, 5) == 0) r[$urandom_range(0, 3)] = 1'b0;
        cycle("random", r, $urandom_range(0, 3) == 0);
      end
    end

    @(posedge aclk);
    #4;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending=%0d, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
